// File: rtl/iq_interp_upsampler.sv
// Buffers signed I/Q baseband pairs in a small FIFO and linearly interpolates them
// up by 2**LOG2_R, producing one registered output pair per clock.
module iq_interp_upsampler #(
  parameter int DATA_W     = 10,
  parameter int LOG2_R     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_i,
  input  logic [DATA_W-1:0]             in_q,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_i,
  output logic [DATA_W-1:0]             out_q,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = DATA_W + 1 + LOG2_R;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, STALL} state_t;

  state_t                   state, state_d;
  logic [LOG2_R-1:0]        phase, phase_d;
  logic signed [DATA_W-1:0] prev_i, prev_q, next_i, next_q;
  logic [DATA_W-1:0]        mem_i [FIFO_DEPTH];
  logic [DATA_W-1:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [LW-1:0]            level;
  logic                     full, empty, push, pop;
  logic                     ld_prev_fifo, ld_next_fifo, shift_prev;
  logic                     emit_interp, emit_hold, underflow_d;

  // y = prev + floor((next - prev) * phase / R); always between prev and next.
  function automatic logic [DATA_W-1:0] interp(input logic signed [DATA_W-1:0] a,
                                               input logic signed [DATA_W-1:0] b,
                                               input logic [LOG2_R-1:0]        ph);
    logic signed [DATA_W:0] d;
    logic signed [PW-1:0]   p;
    d = (DATA_W+1)'(b) - (DATA_W+1)'(a);
    p = PW'(d) * PW'($signed({1'b0, ph}));
    return a + DATA_W'(p >>> LOG2_R);
  endfunction

  assign full       = (level == LW'(FIFO_DEPTH));
  assign empty      = (level == '0);
  assign in_ready   = reset && !full;
  assign push       = in_valid && in_ready;
  assign fifo_level = level;

  always_comb begin
    state_d      = state;
    phase_d      = phase;
    pop          = 1'b0;
    ld_prev_fifo = 1'b0;
    ld_next_fifo = 1'b0;
    shift_prev   = 1'b0;
    emit_interp  = 1'b0;
    emit_hold    = 1'b0;
    underflow_d  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          ld_prev_fifo = 1'b1;
          state_d      = PRIME;
        end
      end
      PRIME: begin
        if (!empty) begin
          pop          = 1'b1;
          ld_next_fifo = 1'b1;
          phase_d      = '0;
          state_d      = RUN;
        end
      end
      RUN: begin
        emit_interp = 1'b1;
        phase_d     = phase + 1'b1;
        if (phase == '1) begin
          shift_prev = 1'b1;
          if (!empty) begin
            pop          = 1'b1;
            ld_next_fifo = 1'b1;
          end else begin
            state_d     = STALL;
            underflow_d = 1'b1;
          end
        end
      end
      STALL: begin
        emit_hold = 1'b1;
        if (!empty) begin
          pop          = 1'b1;
          ld_next_fifo = 1'b1;
          phase_d      = '0;
          state_d      = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      phase     <= '0;
      prev_i    <= '0;
      prev_q    <= '0;
      next_i    <= '0;
      next_q    <= '0;
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      underflow <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else begin
      state     <= state_d;
      phase     <= phase_d;
      underflow <= underflow_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      // At a segment wrap prev takes the old next while next reloads from the FIFO.
      if (ld_prev_fifo) begin
        prev_i <= mem_i[rd_ptr];
        prev_q <= mem_q[rd_ptr];
      end else if (shift_prev) begin
        prev_i <= next_i;
        prev_q <= next_q;
      end
      if (ld_next_fifo) begin
        next_i <= mem_i[rd_ptr];
        next_q <= mem_q[rd_ptr];
      end
      out_valid <= emit_interp || emit_hold;
      if (emit_interp) begin
        out_i <= interp(prev_i, next_i, phase);
        out_q <= interp(prev_q, next_q, phase);
      end else if (emit_hold) begin
        out_i <= prev_i;
        out_q <= prev_q;
      end else begin
        out_i <= '0;
        out_q <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_i[wr_ptr] <= in_i;
      mem_q[wr_ptr] <= in_q;
    end
  end

endmodule

// File: tb/tb_iq_interp_upsampler.sv
// Self-checking bench for iq_interp_upsampler: segment table, directed corner sequences,
// and a randomized stream checked against an arithmetic interpolation model.
module tb_iq_interp_upsampler;

  localparam int DATA_W     = 10;
  localparam int LOG2_R     = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int R          = 1 << LOG2_R;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic              clock    = 1'b0;
  logic              reset    = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_i     = '0;
  logic [DATA_W-1:0] in_q     = '0;
  logic              in_ready, out_valid, underflow;
  logic [DATA_W-1:0] out_i, out_q;
  logic [LW-1:0]     fifo_level;

  int n_vec = 0;
  int n_err = 0;

  iq_interp_upsampler #(.DATA_W(DATA_W), .LOG2_R(LOG2_R), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_i(in_i), .in_q(in_q), .out_valid(out_valid), .out_i(out_i), .out_q(out_q),
    .underflow(underflow), .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [DATA_W-1:0]          ai, bi, aq, bq;
    logic [0:R-1][DATA_W-1:0]   ei, eq;
  } vec_t;

  vec_t tbl [4];
  int   bp_lvl [8] = '{1, 1, 1, 2, 3, 4, 4, 4};

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sx(input logic [DATA_W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int interp_ref(input int a, input int b, input int p);
    int num, q;
    num = (b - a) * p;
    q   = num / R;
    if (num < 0 && num % R != 0) q = q - 1;
    return a + q;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int i, input int q);
    in_valid = 1'b1;
    in_i     = i[DATA_W-1:0];
    in_q     = q[DATA_W-1:0];
    for (int w = 0; w < 40 && !in_ready; w++) tick();
    chk("push_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b0;
    repeat (2) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_i", sx(out_i), 0);
    chk("rst_out_q", sx(out_q), 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_underflow", underflow, 0);
    reset = 1'b1;
    #1;
    chk("rst_release_ready", in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- segment table ----------------
    tbl[0].ai = 10'sd0;    tbl[0].bi = 10'sd80;  tbl[0].aq = 10'sd0;    tbl[0].bq = -10'sd80;
    tbl[0].ei = {10'sd0, 10'sd10, 10'sd20, 10'sd30, 10'sd40, 10'sd50, 10'sd60, 10'sd70};
    tbl[0].eq = {10'sd0, -10'sd10, -10'sd20, -10'sd30, -10'sd40, -10'sd50, -10'sd60, -10'sd70};
    tbl[1].ai = 10'sd0;    tbl[1].bi = -10'sd3;  tbl[1].aq = 10'sd0;    tbl[1].bq = 10'sd3;
    tbl[1].ei = {10'sd0, -10'sd1, -10'sd1, -10'sd2, -10'sd2, -10'sd2, -10'sd3, -10'sd3};
    tbl[1].eq = {10'sd0, 10'sd0, 10'sd0, 10'sd1, 10'sd1, 10'sd1, 10'sd2, 10'sd2};
    tbl[2].ai = 10'sd511;  tbl[2].bi = -10'sd512; tbl[2].aq = -10'sd512; tbl[2].bq = 10'sd511;
    tbl[2].ei = {10'sd511, 10'sd383, 10'sd255, 10'sd127, -10'sd1, -10'sd129, -10'sd257, -10'sd385};
    tbl[2].eq = {-10'sd512, -10'sd385, -10'sd257, -10'sd129, -10'sd1, 10'sd127, 10'sd255, 10'sd383};
    tbl[3].ai = -10'sd100; tbl[3].bi = -10'sd100; tbl[3].aq = 10'sd5;    tbl[3].bq = -10'sd6;
    tbl[3].ei = {8{-10'sd100}};
    tbl[3].eq = {10'sd5, 10'sd3, 10'sd2, 10'sd0, -10'sd1, -10'sd2, -10'sd4, -10'sd5};

    for (int r = 0; r < 4; r++) begin
      int waited;
      do_reset();
      push(sx(tbl[r].ai), sx(tbl[r].aq));
      push(sx(tbl[r].bi), sx(tbl[r].bq));
      waited = 0;
      while (!out_valid && waited < 10) begin
        tick();
        waited++;
      end
      chk($sformatf("tbl%0d_latency", r), waited, 2);
      for (int p = 0; p < R; p++) begin
        chk($sformatf("tbl%0d_i_ph%0d", r, p), sx(out_i), sx(tbl[r].ei[p]));
        chk($sformatf("tbl%0d_q_ph%0d", r, p), sx(out_q), sx(tbl[r].eq[p]));
        chk($sformatf("tbl%0d_valid_ph%0d", r, p), out_valid, 1);
        tick();
      end
    end

    // ---------------- underflow and resume ----------------
    begin
      int uf;
      do_reset();
      push(0, 0);
      push(40, -40);
      push(80, -80);
      for (int w = 0; w < 10 && !out_valid; w++) tick();
      uf = 0;
      for (int n = 0; n < 2 * R; n++) begin
        chk("uf_seg_i", sx(out_i), 5 * n);
        chk("uf_seg_q", sx(out_q), -5 * n);
        chk("uf_seg_valid", out_valid, 1);
        uf += int'(underflow);
        tick();
      end
      for (int n = 0; n < 6; n++) begin
        chk("uf_hold_i", sx(out_i), 80);
        chk("uf_hold_q", sx(out_q), -80);
        chk("uf_hold_valid", out_valid, 1);
        uf += int'(underflow);
        tick();
      end
      chk("uf_pulse_count", uf, 1);
      push(120, -120);
      for (int w = 0; w < 10 && out_valid && sx(out_i) == 80; w++) tick();
      uf = 0;
      for (int n = 1; n < R; n++) begin
        chk("uf_resume_i", sx(out_i), 80 + 5 * n);
        chk("uf_resume_q", sx(out_q), -80 - 5 * n);
        chk("uf_resume_valid", out_valid, 1);
        uf += int'(underflow);
        tick();
      end
      chk("uf_rehold_i", sx(out_i), 120);
      uf += int'(underflow);
      chk("uf_second_pulse", uf, 1);
    end

    // ---------------- backpressure ----------------
    do_reset();
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          in_valid = 1'b1;
          in_i     = DATA_W'(k < 6 ? 16 * k : 300 + k);
          in_q     = DATA_W'(k < 6 ? -16 * k : 200);
          chk($sformatf("bp_ready_beat%0d", k), in_ready, (k < 6) ? 1 : 0);
          tick();
          chk($sformatf("bp_level_beat%0d", k), fifo_level, bp_lvl[k]);
        end
        in_valid = 1'b0;
      end
      begin
        int uf, e;
        for (int w = 0; w < 20 && !out_valid; w++) tick();
        uf = 0;
        for (int n = 0; n < 44; n++) begin
          e = (n < 40) ? 2 * n : 80;
          chk("bp_out_i", sx(out_i), e);
          chk("bp_out_q", sx(out_q), -e);
          chk("bp_out_valid", out_valid, 1);
          chk("bp_level_max", int'(fifo_level <= FIFO_DEPTH), 1);
          uf += int'(underflow);
          tick();
        end
        chk("bp_underflow_count", uf, 1);
      end
    join

    // ---------------- reset mid-RUN ----------------
    do_reset();
    push(0, 0);
    push(80, 80);
    push(160, 160);
    push(240, 240);
    for (int w = 0; w < 30 && !(out_valid && sx(out_i) == 20); w++) tick();
    chk("rm_found_phase2", sx(out_i), 20);
    reset = 1'b0;
    tick();
    chk("rm_out_valid", out_valid, 0);
    chk("rm_out_i", sx(out_i), 0);
    chk("rm_out_q", sx(out_q), 0);
    chk("rm_level", fifo_level, 0);
    chk("rm_underflow", underflow, 0);
    chk("rm_ready_in_reset", in_ready, 0);
    reset = 1'b1;
    #1;
    chk("rm_ready_after", in_ready, 1);
    for (int n = 0; n < 12; n++) begin
      tick();
      chk("rm_no_output", out_valid, 0);
    end

    // ---------------- randomized stream vs model ----------------
    do_reset();
    begin
      int  q_i[$], q_q[$];
      int  last_i, last_q, holds;
      bit  have, draining;
      have = 1'b0; draining = 1'b0; holds = 0; last_i = 0; last_q = 0;
      fork
        begin
          for (int c = 0; c < 1500; c++) begin
            int vi, vq;
            vi       = int'($urandom_range(1023)) - 512;
            vq       = int'($urandom_range(1023)) - 512;
            in_valid = ($urandom_range(3) != 0);
            in_i     = vi[DATA_W-1:0];
            in_q     = vq[DATA_W-1:0];
            tick();
          end
          in_valid = 1'b0;
          draining = 1'b1;
        end
        begin
          for (int c = 0; c < 2200 && holds < 3; c++) begin
            @(negedge clock);
            if (out_valid) begin
              if (q_i.size() > 0) begin
                chk("rnd_out_i", sx(out_i), q_i.pop_front());
                chk("rnd_out_q", sx(out_q), q_q.pop_front());
              end else if (draining) begin
                chk("rnd_hold_i", sx(out_i), last_i);
                chk("rnd_hold_q", sx(out_q), last_q);
                holds++;
              end else begin
                chk("rnd_extra_output", out_valid, 0);
              end
            end
            if (!draining) chk("rnd_underflow", underflow, 0);
            chk("rnd_level_max", int'(fifo_level <= FIFO_DEPTH), 1);
            if (in_valid && in_ready) begin
              if (have) begin
                for (int p = 0; p < R; p++) begin
                  q_i.push_back(interp_ref(last_i, sx(in_i), p));
                  q_q.push_back(interp_ref(last_q, sx(in_q), p));
                end
              end
              last_i = sx(in_i);
              last_q = sx(in_q);
              have   = 1'b1;
            end
          end
          chk("rnd_drain_complete", int'(holds >= 3), 1);
        end
      join
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
